// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
// Bundles the multiply sequencer's request, response, flush and shared-adder
// signals.
//   slave  : seen from mul_seq_ctrl (accepts requests, drives the adder).
//   master : seen from the execute stage and adder owner.
// Signals:
//   req_valid/req_ready/req_mcand/req_mplier  multiply request handshake
//   flush                                     synchronous abort
//   add_req/add_gnt                           shared adder arbitration
//   add_a/add_b/add_ctrl                      adder operands and control
//   add_res/add_cout                          adder sum and carry (same cycle)
//   resp_valid/resp_ready/resp_prod           product response handshake
interface mul_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_mcand;
  logic [WIDTH-1:0]   req_mplier;
  logic               flush;
  logic               add_req;
  logic               add_gnt;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [3:0]         add_ctrl;
  logic [WIDTH-1:0]   add_res;
  logic               add_cout;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*WIDTH-1:0] resp_prod;

  modport slave (
    input  req_valid, req_mcand, req_mplier, flush,
    input  add_gnt, add_res, add_cout, resp_ready,
    output req_ready, add_req, add_a, add_b, add_ctrl, resp_valid, resp_prod
  );

  modport master (
    output req_valid, req_mcand, req_mplier, flush,
    output add_gnt, add_res, add_cout, resp_ready,
    input  req_ready, add_req, add_a, add_b, add_ctrl, resp_valid, resp_prod
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Sequences an unsigned WIDTHxWIDTH -> 2*WIDTH radix-2 shift-add multiply on a
// shared adder it does not own: one partial-product step per granted cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mul_seq_ctrl_if.slave (request, response, flush, adder access)
module mul_seq_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  CTRL_ADD = 4'b0000
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_ctrl_if.slave  bus
);

  localparam int unsigned      CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic               req_ready;
  logic               add_req;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [3:0]         add_ctrl;
  logic               resp_valid;
  logic [2*WIDTH-1:0] resp_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    add_req    = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_ctrl   = CTRL_ADD;
    resp_valid = 1'b0;
    resp_prod  = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid && !bus.flush) begin
          mcand_d = bus.req_mcand;
          hi_d    = '0;
          lo_d    = bus.req_mplier;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_req = 1'b1;
        add_a   = hi_q;
        add_b   = lo_q[0] ? mcand_q : '0;
        if (bus.add_gnt) begin
          // Shift {cout, sum, lo} right by one: the sum's LSB becomes a
          // finished product bit entering lo from the top.
          hi_d = {bus.add_cout, bus.add_res[WIDTH-1:1]};
          lo_d = {bus.add_res[0], lo_q[WIDTH-1:1]};
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_prod  = {hi_q, lo_q};
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition; datapath contents are left stale
    // since they are reloaded on the next accept.
    if (bus.flush) begin
      state_d = S_IDLE;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.add_req    = add_req;
  assign bus.add_a      = add_a;
  assign bus.add_b      = add_b;
  assign bus.add_ctrl   = add_ctrl;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_prod  = resp_prod;

endmodule
